tick_event_scheduler: RTL and testbench

Converts the shared millisecond tick into per-channel periodic events. Software-style configuration sets the period of each of NUM_CH channels. Channels that expire are queued as pending, then arbitrated round-robin onto one valid/ready event port. The block sits between the free-running tick generator and the consumers that must be serviced one at a time: LED sequencers, debouncers and UART pollers.

---
 rtl/tick_sched_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/tick_event_scheduler.sv | 147 ++++++++++++++
 tb/tb_tick_event_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared types and defaults for the tick event scheduler
package tick_sched_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_PER_W  = 10;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from last+1 with wrap
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  int idx;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!any && req[W'(idx)]) begin
        any     = 1'b1;
        gnt_idx = W'(idx);
      end
    end
  end

endmodule

// File: rtl/tick_event_scheduler.sv
// rtl/tick_event_scheduler.sv - per-channel periodic tick counters feeding one
// round-robin valid/ready event port
module tick_event_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int PER_W  = DEF_PER_W,
  parameter int CH_W   = 2
) (
  input  logic              refclk,
  input  logic              reset,
  input  logic              tick,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_en,
  input  logic [PER_W-1:0]  cfg_period,
  output logic              evt_valid,
  output logic [CH_W-1:0]   evt_ch,
  input  logic              evt_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun
);

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;
  logic              accept;

  assign accept    = (state_q == PRESENT) && evt_ready;
  assign evt_valid = valid_q;
  assign evt_ch    = ch_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             en_q, en_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic             cfg_hit, run, expire, acc;

    always_comb begin
      cfg_hit  = cfg_we && (cfg_ch == CH_W'(i));
      run      = tick && en_q && (period_q != '0);
      expire   = run && (cnt_q == PER_W'(1));
      acc      = accept && (ch_q == CH_W'(i));
      en_d     = en_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      ovr_d    = ovr_q;
      // a config write overrides both expiry and the accept clear
      if (cfg_hit) begin
        en_d     = cfg_en;
        period_d = cfg_period;
        cnt_d    = cfg_period;
        pend_d   = 1'b0;
        ovr_d    = 1'b0;
      end else begin
        if (run) begin
          cnt_d = expire ? period_q : cnt_q - PER_W'(1);
        end
        if (expire) begin
          pend_d = 1'b1;
          if (pend_q && !acc) begin
            ovr_d = 1'b1;
          end
        end else if (acc) begin
          pend_d = 1'b0;
        end
      end
    end

    always_ff @(posedge refclk) begin
      if (reset) begin
        en_q     <= 1'b0;
        period_q <= '0;
        cnt_q    <= '0;
        pend_q   <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        en_q     <= en_d;
        period_q <= period_d;
        cnt_q    <= cnt_d;
        pend_q   <= pend_d;
        ovr_q    <= ovr_d;
      end
    end

    assign pending[i] = pend_q;
    assign overrun[i] = ovr_q;
  end

  rr_arbiter #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_arb (
    .req     (pending),
    .last    (last_q),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          ch_d    = arb_idx;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          last_d  = ch_q;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ch_q    <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_tick_event_scheduler.sv
// tb/tb_tick_event_scheduler.sv - directed bench with a tick-counting reference model
module tb_tick_event_scheduler;
  localparam int NUM_CH = 4;
  localparam int PER_W  = 10;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              tick = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic              cfg_en = 1'b0;
  logic [PER_W-1:0]  cfg_period = '0;
  logic              evt_valid;
  logic [CH_W-1:0]   evt_ch;
  logic              evt_ready = 1'b0;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] overrun;

  tick_event_scheduler #(.NUM_CH(NUM_CH), .PER_W(PER_W), .CH_W(CH_W)) dut (
    .refclk(clk), .reset(reset), .tick(tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_en(cfg_en), .cfg_period(cfg_period), .evt_valid(evt_valid), .evt_ch(evt_ch),
    .evt_ready(evt_ready), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;
  int dut_acc[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  // reference model: counts ticks since the last config write per channel
  bit m_en[NUM_CH];
  int m_per[NUM_CH];
  int m_ticks[NUM_CH];
  bit m_pend[NUM_CH];
  bit m_ovr[NUM_CH];
  bit m_valid = 1'b0;
  int m_ch = 0;
  int m_last = NUM_CH - 1;

  task automatic model_step();
    int acc;
    bit exp;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_en[c] = 0; m_per[c] = 0; m_ticks[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
      end
      m_valid = 0; m_ch = 0; m_last = NUM_CH - 1;
    end else begin
      acc = -1;
      if (m_valid) begin
        if (evt_ready) begin
          acc = m_ch; m_last = m_ch; m_valid = 0;
        end
      end else begin
        for (int k = 1; k <= NUM_CH; k++) begin
          if (!m_valid && m_pend[(m_last + k) % NUM_CH]) begin
            m_valid = 1; m_ch = (m_last + k) % NUM_CH;
          end
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_we && int'(cfg_ch) == c) begin
          m_en[c] = cfg_en; m_per[c] = int'(cfg_period); m_ticks[c] = 0;
          m_pend[c] = 0; m_ovr[c] = 0;
        end else begin
          exp = 0;
          if (tick && m_en[c] && m_per[c] != 0) begin
            m_ticks[c]++;
            exp = (m_ticks[c] % m_per[c]) == 0;
          end
          if (exp) begin
            if (m_pend[c] && acc != c) m_ovr[c] = 1;
            m_pend[c] = 1;
          end else if (acc == c) begin
            m_pend[c] = 0;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("m_valid", int'(evt_valid), int'(m_valid));
      if (m_valid) chk("m_ch", int'(evt_ch), m_ch);
      for (int c = 0; c < NUM_CH; c++) begin
        chk($sformatf("m_pend%0d", c), int'(pending[c]), int'(m_pend[c]));
        chk($sformatf("m_ovr%0d", c), int'(overrun[c]), int'(m_ovr[c]));
      end
      if (evt_valid && evt_ready) dut_acc.push_back(int'(evt_ch));
    end
  end

  task automatic clk_n(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic pulse_tick();
    tick = 1'b1; clk_n(1); tick = 1'b0;
  endtask
  task automatic do_cfg(input int ch, input bit en, input int per);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_en = en; cfg_period = PER_W'(per);
    clk_n(1);
    cfg_we = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1; clk_n(1); reset = 1'b0;
  endtask

  initial begin
    int n0, n3;
    clk_n(2);
    do_reset();
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_ch", int'(evt_ch), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_ovr", int'(overrun), 0);

    // ch0 period 3: events two cycles after ticks 3, 6, 9
    evt_ready = 1'b1;
    clk_n(1);
    do_cfg(0, 1, 3);
    for (int k = 1; k <= 9; k++) begin
      pulse_tick();
      @(negedge clk);
      chk("t1_pend", int'(pending[0]), (k % 3 == 0) ? 1 : 0);
      chk("t1_early", int'(evt_valid), 0);
      @(negedge clk);
      chk("t1_valid", int'(evt_valid), (k % 3 == 0) ? 1 : 0);
      if (k % 3 == 0) chk("t1_ch", int'(evt_ch), 0);
      clk_n(17);
    end
    chk("t1_ovr", int'(overrun), 0);

    // all channels period 1: strict round-robin order
    do_reset();
    dut_acc.delete();
    for (int c = 0; c < NUM_CH; c++) do_cfg(c, 1, 1);
    for (int k = 0; k < 3; k++) begin
      pulse_tick();
      clk_n(19);
    end
    chk("t2_cnt", dut_acc.size(), 12);
    for (int i = 0; i < dut_acc.size() && i < 12; i++) chk("t2_order", dut_acc[i], i % 4);
    chk("t2_pend", int'(pending), 0);

    // ch2 stalled consumer: overrun after the 2nd tick, one delivery
    do_reset();
    evt_ready = 1'b0;
    do_cfg(2, 1, 1);
    pulse_tick();
    @(negedge clk);
    chk("t3_ovr_first", int'(overrun[2]), 0);
    clk_n(4);
    pulse_tick();
    @(negedge clk);
    chk("t3_ovr2", int'(overrun[2]), 1);
    chk("t3_valid", int'(evt_valid), 1);
    chk("t3_ch", int'(evt_ch), 2);
    clk_n(4);
    pulse_tick();
    clk_n(3);
    chk("t3_ch_hold", int'(evt_ch), 2);
    dut_acc.delete();
    evt_ready = 1'b1;
    clk_n(6);
    chk("t3_one_evt", dut_acc.size(), 1);
    chk("t3_pend", int'(pending[2]), 0);
    chk("t3_ovr_sticky", int'(overrun[2]), 1);
    do_cfg(2, 0, 1);
    @(negedge clk);
    chk("t3_ovr_clr", int'(overrun[2]), 0);
    clk_n(1);

    // accept of ch1 coincides with its next expiry
    do_reset();
    evt_ready = 1'b0;
    do_cfg(1, 1, 1);
    pulse_tick();
    clk_n(3);
    tick = 1'b1; evt_ready = 1'b1;
    clk_n(1);
    tick = 1'b0; evt_ready = 1'b0;
    @(negedge clk);
    chk("t4_pend", int'(pending[1]), 1);
    chk("t4_ovr", int'(overrun[1]), 0);
    chk("t4_bubble", int'(evt_valid), 0);
    @(negedge clk);
    chk("t4_again", int'(evt_valid), 1);
    chk("t4_ch", int'(evt_ch), 1);
    evt_ready = 1'b1;
    clk_n(3);

    // period 0 is silent; reset drops a presented event
    do_reset();
    dut_acc.delete();
    do_cfg(3, 1, 0);
    do_cfg(0, 1, 2);
    for (int k = 0; k < 4; k++) begin
      pulse_tick();
      @(negedge clk);
      chk("t5_silent3", int'(pending[3]), 0);
      clk_n(9);
    end
    n0 = 0; n3 = 0;
    foreach (dut_acc[i]) begin
      if (dut_acc[i] == 0) n0++;
      if (dut_acc[i] == 3) n3++;
    end
    chk("t5_ch0_evts", n0, 2);
    chk("t5_ch3_evts", n3, 0);
    evt_ready = 1'b0;
    pulse_tick();
    clk_n(2);
    pulse_tick();
    clk_n(2);
    chk("t5_pre_valid", int'(evt_valid), 1);
    do_reset();
    @(negedge clk);
    chk("t5_rst_valid", int'(evt_valid), 0);
    chk("t5_rst_pend", int'(pending), 0);
    evt_ready = 1'b1;
    dut_acc.delete();
    for (int k = 0; k < 3; k++) begin
      pulse_tick();
      clk_n(4);
      chk("t5_quiet", int'(pending), 0);
    end
    chk("t5_no_evt", dut_acc.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
